// File: rtl/mccpu_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct codes,
// ALU operations, datapath select codes, FSM states and the decode bundle.
package mccpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;
  localparam logic [3:0] ALU_SRLV = 4'd12;

  localparam logic [2:0] PCSRC_ALU    = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_RD1    = 3'd3;
  localparam logic [2:0] PCSRC_EXC    = 3'd4;

  localparam logic [1:0] GPRSEL_RD  = 2'd0;
  localparam logic [1:0] GPRSEL_RT  = 2'd1;
  localparam logic [1:0] GPRSEL_R31 = 2'd2;

  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_MEM = 2'd1;
  localparam logic [1:0] WDSEL_PC  = 2'd2;

  localparam logic [1:0] ALUSRCB_RD2  = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM  = 2'd2;
  localparam logic [1:0] ALUSRCB_BOFF = 2'd3;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       i_alu;
    logic       lw;
    logic       sw;
    logic       beq;
    logic       bne;
    logic       j;
    logic       jal;
    logic       jr;
    logic       jalr;
    logic       imm_zext;
    logic [3:0] alu_op;
  } dec_t;

endpackage

// File: rtl/mccpu_decode.sv
// Combinational instruction decode: op/funct to class flags, ALU operation
// and immediate extension mode. Anything unrecognised (including X) is invalid.
module mccpu_decode
  import mccpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    // NOTE: give every output a default before the case so no path infers a latch.
    dec        = '0;
    dec.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        dec.valid = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:          dec.alu_op = ALU_AND;
          FN_OR:           dec.alu_op = ALU_OR;
          FN_NOR:          dec.alu_op = ALU_NOR;
          FN_SLT:          dec.alu_op = ALU_SLT;
          FN_SLTU:         dec.alu_op = ALU_SLTU;
          FN_SLL:          dec.alu_op = ALU_SLL;
          FN_SRL:          dec.alu_op = ALU_SRL;
          FN_SLLV:         dec.alu_op = ALU_SLLV;
          FN_SRLV:         dec.alu_op = ALU_SRLV;
          FN_JR:           dec.jr     = 1'b1;
          FN_JALR:         dec.jalr   = 1'b1;
          default:         dec.valid  = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.valid = 1'b1; dec.i_alu = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SLTI: begin dec.valid = 1'b1; dec.i_alu = 1'b1; dec.alu_op = ALU_SLT; end
      OP_ANDI: begin
        dec.valid = 1'b1; dec.i_alu = 1'b1; dec.imm_zext = 1'b1; dec.alu_op = ALU_AND;
      end
      OP_ORI: begin
        dec.valid = 1'b1; dec.i_alu = 1'b1; dec.imm_zext = 1'b1; dec.alu_op = ALU_OR;
      end
      OP_LUI: begin
        dec.valid = 1'b1; dec.i_alu = 1'b1; dec.imm_zext = 1'b1; dec.alu_op = ALU_LUI;
      end
      OP_LW:   begin dec.valid = 1'b1; dec.lw  = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SW:   begin dec.valid = 1'b1; dec.sw  = 1'b1; dec.alu_op = ALU_ADD; end
      OP_BEQ:  begin dec.valid = 1'b1; dec.beq = 1'b1; dec.alu_op = ALU_SUB; end
      OP_BNE:  begin dec.valid = 1'b1; dec.bne = 1'b1; dec.alu_op = ALU_SUB; end
      OP_J:    begin dec.valid = 1'b1; dec.j   = 1'b1; end
      OP_JAL:  begin dec.valid = 1'b1; dec.jal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mccpu_ctrl_v2.sv
// Multicycle MIPS controller: six-state FSM with memory wait states,
// illegal-instruction trap and a retired-instruction counter.
module mccpu_ctrl_v2
  import mccpu_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          EXC_EN        = 1'b1,
  parameter int unsigned CNT_W         = 32,
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0180
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             reg_write,
  output logic             mem_write,
  output logic             mem_read,
  output logic             pc_write,
  output logic             ir_write,
  output logic             epc_write,
  output logic             ext_op,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [2:0]       pc_source,
  output logic [1:0]       gpr_sel,
  output logic [1:0]       wd_sel,
  output logic             i_or_d,
  output logic [31:0]      exc_vector,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t state, state_nxt;
  dec_t   dec;
  logic   rdy, is_jump, retire;

  mccpu_decode u_decode (.op(op), .funct(funct), .dec(dec));

  assign rdy        = mem_ready | ~MEM_HANDSHAKE;
  assign is_jump    = dec.j | dec.jal | dec.jr | dec.jalr;
  assign exc_vector = EXC_VECTOR;

  // An instruction retires on its last cycle; trapped instructions never do.
  assign retire = (state == S_ID  && dec.valid && is_jump) ||
                  (state == S_EXE && (dec.beq || dec.bne)) ||
                  (state == S_MEM && dec.sw && rdy) ||
                  (state == S_WB);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IF;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:  state_nxt = rdy ? S_ID : S_IF;
      S_ID: begin
        if (!dec.valid)   state_nxt = EXC_EN ? S_EXC : S_IF;
        else if (is_jump) state_nxt = S_IF;
        else              state_nxt = S_EXE;
      end
      S_EXE: begin
        if (dec.beq || dec.bne)    state_nxt = S_IF;
        else if (dec.lw || dec.sw) state_nxt = S_MEM;
        else                       state_nxt = S_WB;
      end
      S_MEM: begin
        if (!rdy)       state_nxt = S_MEM;
        else if (dec.lw) state_nxt = S_WB;
        else            state_nxt = S_IF;
      end
      default: state_nxt = S_IF;
    endcase
  end

  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    epc_write = 1'b0;
    ext_op    = 1'b1;
    alu_src_a = 1'b1;
    alu_src_b = ALUSRCB_RD2;
    alu_op    = ALU_ADD;
    pc_source = PCSRC_ALU;
    gpr_sel   = GPRSEL_RD;
    wd_sel    = WDSEL_ALU;
    i_or_d    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_a = 1'b0;
        alu_src_b = ALUSRCB_FOUR;
        pc_write  = rdy;
        ir_write  = rdy;
      end
      S_ID: begin
        if (dec.valid) begin
          if (dec.j || dec.jal) begin
            pc_source = PCSRC_JUMP;
            pc_write  = 1'b1;
          end else if (dec.jr || dec.jalr) begin
            pc_source = PCSRC_RD1;
            pc_write  = 1'b1;
          end else begin
            alu_src_a = 1'b0;
            alu_src_b = ALUSRCB_BOFF;
          end
          if (dec.jal || dec.jalr) begin
            reg_write = 1'b1;
            wd_sel    = WDSEL_PC;
            gpr_sel   = dec.jal ? GPRSEL_R31 : GPRSEL_RD;
          end
        end
      end
      S_EXE: begin
        alu_op = dec.alu_op;
        ext_op = ~dec.imm_zext;
        if (dec.beq || dec.bne) begin
          pc_source = PCSRC_ALUOUT;
          pc_write  = dec.beq ? zero : ~zero;
        end
        if (dec.i_alu || dec.lw || dec.sw) alu_src_b = ALUSRCB_IMM;
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = dec.lw;
        mem_write = dec.sw;
      end
      S_WB: begin
        reg_write = 1'b1;
        if (dec.lw)               wd_sel  = WDSEL_MEM;
        if (dec.i_alu || dec.lw)  gpr_sel = GPRSEL_RT;
      end
      S_EXC: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_source = PCSRC_EXC;
        illegal   = 1'b1;
      end
      default: ;
    endcase
    // Reset is asynchronous, so block every write the instant rst_n falls.
    if (!rst_n) begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      epc_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_mccpu_ctrl_v2.sv
// Directed bench for mccpu_ctrl_v2: a default-parameter instance plus one with
// no handshake, no trap and a 4-bit retired counter.
module tb_mccpu_ctrl_v2;
  import mccpu_pkg::*;

  typedef struct packed {
    logic       reg_write, mem_write, mem_read, pc_write, ir_write, epc_write;
    logic       ext_op, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [2:0] pc_source;
    logic [1:0] gpr_sel, wd_sel;
    logic       i_or_d, illegal;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] op, funct;

  logic        reg_write, mem_write, mem_read, pc_write, ir_write, epc_write;
  logic        ext_op, alu_src_a, i_or_d, illegal;
  logic [1:0]  alu_src_b, gpr_sel, wd_sel;
  logic [3:0]  alu_op;
  logic [2:0]  pc_source;
  logic [31:0] exc_vector, retired;

  logic        b_reg_write, b_mem_write, b_mem_read, b_pc_write, b_ir_write, b_epc_write;
  logic        b_ext_op, b_alu_src_a, b_i_or_d, b_illegal;
  logic [1:0]  b_alu_src_b, b_gpr_sel, b_wd_sel;
  logic [3:0]  b_alu_op;
  logic [2:0]  b_pc_source;
  logic [31:0] b_exc_vector;
  logic [3:0]  b_retired;

  ctrl_t obs, obs_b, e;
  int    n_asserts = 0;
  int    n_fail    = 0;

  always #5 clk = ~clk;

  mccpu_ctrl_v2 dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .reg_write(reg_write), .mem_write(mem_write), .mem_read(mem_read), .pc_write(pc_write),
    .ir_write(ir_write), .epc_write(epc_write), .ext_op(ext_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .gpr_sel(gpr_sel),
    .wd_sel(wd_sel), .i_or_d(i_or_d), .exc_vector(exc_vector), .illegal(illegal),
    .retired(retired)
  );

  mccpu_ctrl_v2 #(.MEM_HANDSHAKE(1'b0), .EXC_EN(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .reg_write(b_reg_write), .mem_write(b_mem_write), .mem_read(b_mem_read),
    .pc_write(b_pc_write), .ir_write(b_ir_write), .epc_write(b_epc_write),
    .ext_op(b_ext_op), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .pc_source(b_pc_source), .gpr_sel(b_gpr_sel), .wd_sel(b_wd_sel),
    .i_or_d(b_i_or_d), .exc_vector(b_exc_vector), .illegal(b_illegal),
    .retired(b_retired)
  );

  assign obs = {reg_write, mem_write, mem_read, pc_write, ir_write, epc_write, ext_op,
                alu_src_a, alu_src_b, alu_op, pc_source, gpr_sel, wd_sel, i_or_d, illegal};
  assign obs_b = {b_reg_write, b_mem_write, b_mem_read, b_pc_write, b_ir_write, b_epc_write,
                  b_ext_op, b_alu_src_a, b_alu_src_b, b_alu_op, b_pc_source, b_gpr_sel,
                  b_wd_sel, b_i_or_d, b_illegal};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Check the control word mid-cycle, then step to just after the next rising edge.
  task automatic cyc(input string tag, input ctrl_t exp_c, input bit use_b);
    @(negedge clk);
    check(tag, use_b ? 32'(obs_b) : 32'(obs), 32'(exp_c));
    @(posedge clk);
    #1;
  endtask

  function automatic ctrl_t dflt();
    ctrl_t c;
    c           = '0;
    c.ext_op    = 1'b1;
    c.alu_src_a = 1'b1;
    c.alu_op    = ALU_ADD;
    return c;
  endfunction

  function automatic ctrl_t if_exp(input bit r);
    ctrl_t c;
    c           = dflt();
    c.mem_read  = 1'b1;
    c.alu_src_a = 1'b0;
    c.alu_src_b = ALUSRCB_FOUR;
    c.pc_write  = r;
    c.ir_write  = r;
    return c;
  endfunction

  function automatic ctrl_t id_exp();
    ctrl_t c;
    c           = dflt();
    c.alu_src_a = 1'b0;
    c.alu_src_b = ALUSRCB_BOFF;
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; op = OP_RTYPE; funct = FN_ADD; zero = 1'b0; mem_ready = 1'b1;
    #2;
    check("reset ctl", 32'(obs), 32'(if_exp(1'b0)));
    check("reset retired", retired, 32'd0);
    check("exc_vector", exc_vector, 32'h0000_0180);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add: IF ID EXE WB
    cyc("add IF", if_exp(1'b1), 1'b0);
    cyc("add ID", id_exp(), 1'b0);
    cyc("add EXE", dflt(), 1'b0);
    check("add retired before WB", retired, 32'd0);
    e = dflt(); e.reg_write = 1'b1;
    cyc("add WB", e, 1'b0);
    check("add retired", retired, 32'd1);

    // lw with two MEM wait cycles
    op = OP_LW;
    cyc("lw IF", if_exp(1'b1), 1'b0);
    cyc("lw ID", id_exp(), 1'b0);
    e = dflt(); e.alu_src_b = ALUSRCB_IMM;
    cyc("lw EXE", e, 1'b0);
    mem_ready = 1'b0;
    e = dflt(); e.mem_read = 1'b1; e.i_or_d = 1'b1;
    cyc("lw MEM wait1", e, 1'b0);
    cyc("lw MEM wait2", e, 1'b0);
    check("lw retired during wait", retired, 32'd1);
    mem_ready = 1'b1;
    cyc("lw MEM ready", e, 1'b0);
    e = dflt(); e.reg_write = 1'b1; e.wd_sel = WDSEL_MEM; e.gpr_sel = GPRSEL_RT;
    cyc("lw WB", e, 1'b0);
    check("lw retired", retired, 32'd2);

    // beq z=1, beq z=0, bne z=1, bne z=0; the first one waits once in IF
    for (int k = 0; k < 4; k++) begin
      op   = (k < 2) ? OP_BEQ : OP_BNE;
      zero = (k % 2 == 0);
      if (k == 0) begin
        mem_ready = 1'b0;
        cyc("br IF wait", if_exp(1'b0), 1'b0);
        mem_ready = 1'b1;
      end
      cyc("br IF", if_exp(1'b1), 1'b0);
      cyc("br ID", id_exp(), 1'b0);
      e = dflt(); e.alu_op = ALU_SUB; e.pc_source = PCSRC_ALUOUT;
      e.pc_write = (k == 0 || k == 3);
      cyc($sformatf("br EXE k=%0d", k), e, 1'b0);
      check($sformatf("br retired k=%0d", k), retired, 32'(3 + k));
    end

    // j
    op = OP_J;
    cyc("j IF", if_exp(1'b1), 1'b0);
    e = dflt(); e.pc_source = PCSRC_JUMP; e.pc_write = 1'b1;
    cyc("j ID", e, 1'b0);
    check("j retired", retired, 32'd7);

    // jal
    op = OP_JAL;
    cyc("jal IF", if_exp(1'b1), 1'b0);
    e.reg_write = 1'b1; e.wd_sel = WDSEL_PC; e.gpr_sel = GPRSEL_R31;
    cyc("jal ID", e, 1'b0);
    check("jal retired", retired, 32'd8);

    // jalr
    op = OP_RTYPE; funct = FN_JALR;
    cyc("jalr IF", if_exp(1'b1), 1'b0);
    e = dflt(); e.pc_source = PCSRC_RD1; e.pc_write = 1'b1;
    e.reg_write = 1'b1; e.wd_sel = WDSEL_PC; e.gpr_sel = GPRSEL_RD;
    cyc("jalr ID", e, 1'b0);
    check("jalr retired", retired, 32'd9);

    // ori: zero-extended immediate
    op = OP_ORI;
    cyc("ori IF", if_exp(1'b1), 1'b0);
    cyc("ori ID", id_exp(), 1'b0);
    e = dflt(); e.alu_src_b = ALUSRCB_IMM; e.alu_op = ALU_OR; e.ext_op = 1'b0;
    cyc("ori EXE", e, 1'b0);
    e = dflt(); e.reg_write = 1'b1; e.gpr_sel = GPRSEL_RT;
    cyc("ori WB", e, 1'b0);
    check("ori retired", retired, 32'd10);

    // illegal opcode traps
    op = 6'h3F;
    cyc("ill IF", if_exp(1'b1), 1'b0);
    cyc("ill ID", dflt(), 1'b0);
    e = dflt(); e.epc_write = 1'b1; e.pc_write = 1'b1; e.pc_source = PCSRC_EXC; e.illegal = 1'b1;
    cyc("ill EXC", e, 1'b0);
    check("ill retired", retired, 32'd10);

    // sw, reset while waiting in MEM
    op = OP_SW;
    cyc("sw IF (illegal cleared)", if_exp(1'b1), 1'b0);
    cyc("sw ID", id_exp(), 1'b0);
    e = dflt(); e.alu_src_b = ALUSRCB_IMM;
    cyc("sw EXE", e, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    e = dflt(); e.mem_write = 1'b1; e.i_or_d = 1'b1;
    check("sw MEM wait", 32'(obs), 32'(e));
    #1 rst_n = 1'b0;
    #1;
    check("sw reset ctl", 32'(obs), 32'(if_exp(1'b0)));
    check("sw reset retired", retired, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1;

    // sw completing with no wait
    cyc("sw2 IF", if_exp(1'b1), 1'b0);
    cyc("sw2 ID", id_exp(), 1'b0);
    e = dflt(); e.alu_src_b = ALUSRCB_IMM;
    cyc("sw2 EXE", e, 1'b0);
    e = dflt(); e.mem_write = 1'b1; e.i_or_d = 1'b1;
    cyc("sw2 MEM", e, 1'b0);
    check("sw2 retired", retired, 32'd1);

    // Second instance: no handshake, no trap, 4-bit counter
    rst_n = 1'b0;
    #1;
    check("b reset retired", 32'(b_retired), 32'd0);
    check("b exc_vector", b_exc_vector, 32'h0000_0180);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b0; op = 6'h3F;
    cyc("b ill IF no handshake", if_exp(1'b1), 1'b1);
    cyc("b ill ID", dflt(), 1'b1);
    op = OP_J;
    cyc("b IF after illegal", if_exp(1'b1), 1'b1);
    check("b ill retired", 32'(b_retired), 32'd0);
    e = dflt(); e.pc_source = PCSRC_JUMP; e.pc_write = 1'b1;
    cyc("b j ID", e, 1'b1);
    check("b retired 1", 32'(b_retired), 32'd1);
    for (int i = 2; i <= 17; i++) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (i == 16) check("b retired wrap 16", 32'(b_retired), 32'd0);
    end
    check("b retired 17", 32'(b_retired), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mccpu_ctrl_v2.md
# mccpu_ctrl_v2

Parametrised multicycle MIPS control unit: next generation of the multicycle CPU controller. Decodes the instruction register fields each cycle and drives all datapath enables and mux selects through a six-state FSM (IF/ID/EXE/MEM/WB/EXC). Over the previous controller it adds:

- a memory ready handshake, which inserts wait states;
- an illegal-instruction trap with EPC capture;
- a retired-instruction counter.

It sits between the instruction register and the multicycle datapath (PC, IR, regfile, ALU, ALUOut, memory).

## Interface
Parameters:
- MEM_HANDSHAKE, 1: 1 = IF/MEM wait for mem_ready; 0 = memory treated as always ready.
- EXC_EN, 1: 1 = illegal opcode/funct enters EXC; 0 = silently returns to IF.
- CNT_W, 32: width of retired-instruction counter.
- EXC_VECTOR, 32'h0000_0180: trap target, driven on exc_vector.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- op  in  6  instruction opcode (IR[31:26]).
- funct  in  6  instruction funct (IR[5:0]).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- reg_write, mem_write, mem_read, pc_write, ir_write, epc_write  out  1 each  datapath enables.
- ext_op  out  1  1 = sign extend, 0 = zero extend.
- alu_src_a  out  1  0 = PC, 1 = RD1.
- alu_src_b  out  2  00 RD2, 01 const 4, 10 ext imm, 11 branch offset.
- alu_op  out  4  ALU operation (package encoding, NOP..SRLV = 0..12).
- pc_source  out  3  000 ALU, 001 ALUOut, 010 jump addr, 011 RD1, 100 exc_vector.
- gpr_sel  out  2  00 rd, 01 rt, 10 r31.
- wd_sel  out  2  00 ALU, 01 MEM, 10 PC.
- i_or_d  out  1  0 = instruction address, 1 = ALUOut.
- exc_vector  out  32  constant EXC_VECTOR.
- illegal  out  1  one-cycle pulse in EXC.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Supported set: the full 26-instruction set of the previous controller.
  - R: add, addu, sub, subu, and, or, nor, slt, sltu, sll, srl, sllv, srlv, jr, jalr.
  - I: addi, andi, ori, slti, lui, lw, sw, beq, bne.
  - J: j, jal.
- Defaults each cycle: all enables 0, ext_op 1, alu_src_a 1, alu_src_b 00, alu_op ADD, pc_source 000, gpr_sel 00, wd_sel 00, i_or_d 0.
- IF: mem_read=1, alu_src_a=0, alu_src_b=01. pc_write and ir_write are asserted only when rdy. Stay in IF while !rdy; otherwise go to ID.
  - rdy = mem_ready | ~MEM_HANDSHAKE.
- ID:
  - Illegal (including X/Z decode): EXC if EXC_EN, else IF.
  - j: pc_source 010, pc_write. Then IF.
  - jal: as j, plus reg_write, wd_sel 10, gpr_sel 10. Then IF.
  - jr: pc_source 011, pc_write. Then IF.
  - jalr: as jr, plus reg_write, wd_sel 10, gpr_sel 00. Then IF.
  - Otherwise: alu_src_a 0, alu_src_b 11. Then EXE.
- EXE: alu_op from the decode.
  - beq: pc_source 001, pc_write=zero. Then IF.
  - bne: pc_source 001, pc_write=~zero. Then IF.
  - lw/sw: alu_src_b 10. Then MEM.
  - addi/andi/ori/slti/lui: alu_src_b 10. ext_op 0 for andi, ori, lui. Then WB.
  - Otherwise: WB.
- MEM: i_or_d 1.
  - lw: mem_read. Go to WB when rdy.
  - sw: mem_write held until rdy. Go to IF when rdy.
  - Stay in MEM while !rdy.
- WB: reg_write.
  - lw: wd_sel 01.
  - I-type ALU and lw: gpr_sel 01.
  - Then IF.
- EXC: epc_write, pc_write, pc_source 100, illegal=1. Then IF.
- retired increments by 1 on the final cycle of each legal instruction:
  - the ID exit for jumps;
  - the EXE exit for branches;
  - the MEM exit with rdy for sw;
  - WB.
- retired does not increment for EXC, and wraps at 2^CNT_W−1 → 0.
- State encoding is one-hot or binary (implementer's choice). Unused codes go to IF.

## Timing
- rst_n low: state=IF and retired=0 immediately. All write enables (reg_write, mem_write, pc_write, ir_write, epc_write) are forced 0 while rst_n is low. Selects take their IF values.
- Reset mid-instruction: the instruction is abandoned; no partial write after rst_n asserts.
- Zero-wait latencies:
  - j/jal/jr/jalr: 2 cycles.
  - beq/bne: 3.
  - R/I ALU: 4.
  - sw: 4.
  - lw: 5.
  - illegal: 3.
- Each !rdy cycle in IF or MEM adds exactly one cycle. No outputs change during a wait except hold of mem_read/mem_write.
- Outputs are combinational from state and decode (Mealy on zero/mem_ready). Only state and retired are registered.

## Structure
- Package mccpu_pkg holds:
  - opcode/funct localparams;
  - the ALU_* 4-bit codes;
  - the PCSRC_*, GPRSEL_*, WDSEL_* and ALUSRCB_* codes;
  - the state enum.
- Sub-module mccpu_decode (combinational): op/funct → instruction class one-hots, valid, alu_op, imm_zext.
- The FSM and counter live in mccpu_ctrl_v2.

## Test plan
- add (op 0, funct 0x20), mem_ready=1 → IF, ID, EXE, WB in 4 cycles. WB has reg_write=1, gpr_sel 00, wd_sel 00. retired 0→1.
- lw with mem_ready low for 2 cycles in MEM → lw takes 7 cycles total, with mem_read/i_or_d held. WB has wd_sel 01, gpr_sel 01.
- beq with zero=1, then with zero=0 → the EXE cycle has pc_write 1 with pc_source 001, then pc_write 0. bne gives the opposite result.
- op 0x3F → ID then EXC. EXC has epc_write=1, pc_source 100, illegal pulse 1 cycle, and retired unchanged. With EXC_EN=0 the instruction returns to IF after ID, with no epc_write.
- CNT_W=4, retire 17 instructions → retired = 1 (wrap). Pulse rst_n low in the MEM state of sw → mem_write drops immediately, state is IF, retired is 0.
